// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures hsync/vsync periods, locks after good frames
// and recovers x/y/video_on. Define VGA_MON_PULSE_CHECK_EN to also check sync pulse widths.
module vga_sync_monitor #(
  parameter int H_TOTAL      = 800,
  parameter int H_DISPLAY    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_WIDTH = 96,
  parameter int V_TOTAL      = 525,
  parameter int V_DISPLAY    = 480,
  parameter int V_SYNC_START = 513,
  parameter int V_SYNC_WIDTH = 2,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic [7:0]  err_count
);

  localparam logic [10:0] CNT_MAX     = 11'h7FF;
  localparam logic [10:0] TIMEOUT_PRE = 11'h7FE;
  localparam logic [10:0] H_TOTAL_W   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W   = 11'(V_TOTAL);
  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_SS        = 10'(H_SYNC_START);
  localparam logic [9:0]  H_DISP      = 10'(H_DISPLAY);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SS        = 10'(V_SYNC_START);
  localparam logic [9:0]  V_DISP      = 10'(V_DISPLAY);
  localparam logic [3:0]  LOCK_W      = 4'(LOCK_FRAMES);

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock
    $error("LOCK_FRAMES must be 1..15");
  end
  if (H_TOTAL > 1024 || H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_bad_h
    $error("horizontal timing does not fit the 10-bit column counter");
  end
  if (V_TOTAL > 1024 || V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_bad_v
    $error("vertical timing does not fit the 10-bit row counter");
  end

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        h_valid_q, h_valid_d;
  logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  err_count_q, err_count_d;

  state_t      state_q;
  logic [3:0]  good_cnt_q;
  logic        v_valid_q;
  logic        locked_q, video_on_q;

  logic        h_edge, v_edge, line_done, x_wrap, vis_d;
  logic [10:0] line_meas, v_meas_cnt;
  logic [3:0]  good_inc;
  logic        err_line, err_timeout, err_frame, err_pulse, err_any;

  assign h_edge      = p_tick && hsync_in && !hs_prev_q;
  assign v_edge      = p_tick && vsync_in && !vs_prev_q;
  assign line_done   = h_edge && h_valid_q;
  assign line_meas   = h_meas_q + 11'd1;
  // A line closing on the same tick as vsync belongs to the frame being closed.
  assign v_meas_cnt  = (line_done && v_meas_q != CNT_MAX) ? v_meas_q + 11'd1 : v_meas_q;
  assign err_line    = line_done && (line_meas != H_TOTAL_W);
  assign err_timeout = p_tick && !h_edge && h_valid_q && (h_meas_q == TIMEOUT_PRE);
  assign err_frame   = v_edge && v_valid_q && (v_meas_cnt != V_TOTAL_W);
  assign err_any     = err_line || err_timeout || err_frame || err_pulse;
  assign x_wrap      = !h_edge && (x_q == H_LAST);
  assign good_inc    = good_cnt_q + 4'd1;

`ifdef VGA_MON_PULSE_CHECK_EN
  localparam logic [10:0] HSW_W = 11'(H_SYNC_WIDTH);
  localparam logic [10:0] VSW_W = 11'(V_SYNC_WIDTH);

  logic [10:0] hw_q, vw_q;
  logic        hw_arm_q, vw_arm_q;
  logic        h_fall, v_fall;

  assign h_fall    = p_tick && !hsync_in && hs_prev_q;
  assign v_fall    = p_tick && !vsync_in && vs_prev_q;
  assign err_pulse = (h_fall && hw_arm_q && hw_q != HSW_W) ||
                     (v_fall && vw_arm_q && vw_q != VSW_W);

  // vsync width is counted in hsync edges seen while vsync is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_q     <= '0;
      vw_q     <= '0;
      hw_arm_q <= 1'b0;
      vw_arm_q <= 1'b0;
    end else if (p_tick) begin
      if (h_edge) begin
        hw_q     <= 11'd1;
        hw_arm_q <= 1'b1;
      end else if (hsync_in && hs_prev_q) begin
        if (hw_q != CNT_MAX) hw_q <= hw_q + 11'd1;
      end else if (h_fall) begin
        hw_arm_q <= 1'b0;
      end
      if (v_edge) begin
        vw_q     <= {10'd0, h_edge};
        vw_arm_q <= 1'b1;
      end else if (vsync_in && h_edge) begin
        if (vw_q != CNT_MAX) vw_q <= vw_q + 11'd1;
      end else if (v_fall) begin
        vw_arm_q <= 1'b0;
      end
    end
  end
`else
  assign err_pulse = 1'b0;
`endif

  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_meas_d      = h_meas_q;
    h_valid_d     = h_valid_q;
    v_meas_d      = v_meas_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    x_d           = x_q;
    y_d           = y_q;
    err_count_d   = err_count_q;
    if (p_tick) begin
      hs_prev_d = hsync_in;
      vs_prev_d = vsync_in;
      if (h_edge)                 h_meas_d = '0;
      else if (h_meas_q != CNT_MAX) h_meas_d = h_meas_q + 11'd1;
      // An hsync edge always (re)starts measurement, even on an error tick.
      if (h_edge)       h_valid_d = 1'b1;
      else if (err_any) h_valid_d = 1'b0;
      if (line_done) line_len_d = line_meas;
      v_meas_d = v_edge ? 11'd0 : v_meas_cnt;
      if (v_edge) frame_lines_d = v_meas_cnt;
      if (h_edge)      x_d = H_SS;
      else if (x_wrap) x_d = '0;
      else             x_d = x_q + 10'd1;
      if (v_edge)      y_d = V_SS;
      else if (x_wrap) y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      if (err_any && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  assign vis_d = (x_d < H_DISP) && (y_d < V_DISP);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      h_meas_q      <= '0;
      h_valid_q     <= 1'b0;
      v_meas_q      <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      err_count_q   <= '0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_meas_q      <= h_meas_d;
      h_valid_q     <= h_valid_d;
      v_meas_q      <= v_meas_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      x_q           <= x_d;
      y_q           <= y_d;
      err_count_q   <= err_count_d;
    end
  end

  // The frame that starts on the ACQUIRE-entry edge only arms checking;
  // good frames are counted from the next one on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SEARCH;
      good_cnt_q <= '0;
      v_valid_q  <= 1'b0;
      locked_q   <= 1'b0;
      video_on_q <= 1'b0;
    end else if (p_tick) begin
      if (err_any) begin
        state_q    <= S_SEARCH;
        good_cnt_q <= '0;
        v_valid_q  <= 1'b0;
        locked_q   <= 1'b0;
        video_on_q <= 1'b0;
      end else begin
        video_on_q <= locked_q && vis_d;
        if (v_edge) begin
          unique case (state_q)
            S_SEARCH: begin
              state_q    <= S_ACQUIRE;
              good_cnt_q <= '0;
            end
            S_ACQUIRE: begin
              v_valid_q <= 1'b1;
              if (v_valid_q) begin
                good_cnt_q <= good_inc;
                if (good_inc >= LOCK_W) begin
                  state_q    <= S_LOCKED;
                  locked_q   <= 1'b1;
                  video_on_q <= vis_d;
                end
              end
            end
            S_LOCKED: v_valid_q <= 1'b1;
            default: begin
              state_q    <= S_SEARCH;
              good_cnt_q <= '0;
              locked_q   <= 1'b0;
              video_on_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign locked      = locked_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled-down 20x10 timing; a small sync
// generator drives the DUT with p_tick every second clk.
module tb_vga_sync_monitor;

  localparam int HT = 20, HD = 12, HSS = 14, HSW = 3;
  localparam int VT = 10, VD = 6,  VSS = 7,  VSW = 2;
  localparam int LF = 2;
`ifdef VGA_MON_PULSE_CHECK_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, p_tick, hsync_in, vsync_in;
  logic        locked, video_on;
  logic [9:0]  x, y;
  logic [10:0] line_len, frame_lines;
  logic [7:0]  err_count;

  int n_pass = 0, n_checks = 0;
  int gx, gy, voff, short_row;
  bit hold, hs_force, vs_force;
  bit hs_prev, vs_prev, h_rise, h_fall, v_rise;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
    .V_TOTAL(VT), .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .locked(locked), .x(x), .y(y), .video_on(video_on), .line_len(line_len),
    .frame_lines(frame_lines), .err_count(err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic bit gen_hs();
    int w;
    w = (gy == short_row) ? HSW - 1 : HSW;
    return !hs_force && gx >= HSS && gx < HSS + w;
  endfunction

  function automatic bit gen_vs();
    int p;
    p = gy * HT + gx;
    return !vs_force && p >= VSS * HT + voff && p < (VSS + VSW) * HT + voff;
  endfunction

  // One pixel tick: drive at negedge, DUT samples at posedge, return at the next negedge.
  task automatic tick();
    bit hs, vs;
    hs = gen_hs();
    vs = gen_vs();
    @(negedge clk);
    p_tick = 1'b1; hsync_in = hs; vsync_in = vs;
    @(negedge clk);
    p_tick = 1'b0;
    h_rise = hs && !hs_prev;
    h_fall = !hs && hs_prev;
    v_rise = vs && !vs_prev;
    hs_prev = hs;
    vs_prev = vs;
    if (hold) hold = 1'b0;
    else begin
      gx++;
      if (gx == HT) begin
        gx = 0;
        gy++;
        if (gy == VT) gy = 0;
      end
    end
  endtask

  task automatic run_vsyncs(input int n);
    int seen = 0;
    for (int i = 0; i < (n + 1) * HT * VT && seen < n; i++) begin
      tick();
      if (v_rise) seen++;
    end
  endtask

  task automatic run_to_hrise();
    h_rise = 1'b0;
    for (int i = 0; i < 3 * HT && !h_rise; i++) tick();
  endtask

  task automatic run_to_hfall();
    h_fall = 1'b0;
    for (int i = 0; i < 3 * HT && !h_fall; i++) tick();
  endtask

  task automatic run_to(input int tx, input int ty);
    for (int i = 0; i < 2 * HT * VT && !(gx == tx && gy == ty); i++) tick();
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    gx = 0; gy = 0; voff = 0; short_row = -1;
    hold = 1'b0; hs_force = 1'b0; vs_force = 1'b0;
    hs_prev = 1'b0; vs_prev = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_video_on", video_on, 0);
    check_eq("rst_line_len", line_len, 0);
    check_eq("rst_frame_lines", frame_lines, 0);
    check_eq("rst_err_count", err_count, 0);
    reset = 1'b0;

    // acquisition from reset on an ideal stream
    run_vsyncs(1);
    check_eq("acq_v1_locked", locked, 0);
    check_eq("acq_v1_x", x, 0);
    check_eq("acq_v1_y", y, VSS);
    run_vsyncs(2);
    check_eq("acq_v3_locked", locked, 0);
    run_vsyncs(1);
    check_eq("acq_v4_locked", locked, 1);
    check_eq("acq_line_len", line_len, HT);
    check_eq("acq_frame_lines", frame_lines, VT);
    check_eq("acq_err_count", err_count, 0);
    run_to(3, 2);
    tick();
    check_eq("vis_x", x, 3);
    check_eq("vis_y", y, 2);
    check_eq("vis_video_on", video_on, 1);
    run_to(13, 2);
    tick();
    check_eq("hblank_video_on", video_on, 0);
    run_to(3, VD);
    tick();
    check_eq("vblank_video_on", video_on, 0);

    // one line stretched by a tick
    run_to(5, 2);
    hold = 1'b1;
    run_to_hrise();
    check_eq("stretch_line_len", line_len, HT + 1);
    check_eq("stretch_locked", locked, 0);
    check_eq("stretch_err_count", err_count, 1);
    run_to_hrise();
    check_eq("stretch_next_line_len", line_len, HT);
    run_vsyncs(3);
    check_eq("stretch_v3_locked", locked, 0);
    run_vsyncs(1);
    check_eq("stretch_relock", locked, 1);
    check_eq("stretch_err_hold", err_count, 1);

    // signal loss: hsync timeout 2047 ticks after the last hsync edge
    run_to(0, 2);
    run_to_hrise();
    repeat (3) tick();
    hs_force = 1'b1;
    vs_force = 1'b1;
    repeat (2043) tick();
    check_eq("timeout_pre_err", err_count, 1);
    check_eq("timeout_pre_locked", locked, 1);
    tick();
    check_eq("timeout_err", err_count, 2);
    check_eq("timeout_locked", locked, 0);
    run_to(0, 0);
    hs_force = 1'b0;
    vs_force = 1'b0;
    run_vsyncs(4);
    check_eq("timeout_relock", locked, 1);
    check_eq("timeout_err_hold", err_count, 2);

    // vsync moved to one tick before the hsync edge of its line
    run_to(0, 0);
    voff = HSS - 1;
    run_vsyncs(1);
    check_eq("early_vs_x", x, HSS - 1);
    check_eq("early_vs_y", y, VSS);
    run_vsyncs(1);
    check_eq("early_vs_err", err_count, 2);
    check_eq("early_vs_locked", locked, 1);
    check_eq("early_vs_frame_lines", frame_lines, VT);

    // one-clk reset mid-frame while locked, with p_tick high
    run_to(5, 3);
    check_eq("pre_reset_locked", locked, 1);
    @(negedge clk);
    reset = 1'b1; p_tick = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    reset = 1'b0; p_tick = 1'b0;
    check_eq("mid_rst_x", x, 0);
    check_eq("mid_rst_y", y, 0);
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_err_count", err_count, 0);
    check_eq("mid_rst_line_len", line_len, 0);
    check_eq("mid_rst_frame_lines", frame_lines, 0);

    // vsync coincident with hsync, from a fresh start
    gx = 0; gy = 0; hs_prev = 1'b0; vs_prev = 1'b0;
    voff = HSS;
    run_vsyncs(1);
    check_eq("coinc_x", x, HSS);
    check_eq("coinc_y", y, VSS);
    run_vsyncs(3);
    check_eq("coinc_locked", locked, 1);
    check_eq("coinc_err_count", err_count, 0);
    check_eq("coinc_frame_lines", frame_lines, VT);

    // one hsync pulse a tick short
    run_to(0, 2);
    short_row = 2;
    run_to_hfall();
    short_row = -1;
    check_eq("short_pulse_locked", locked, PULSE ? 0 : 1);
    check_eq("short_pulse_err", err_count, PULSE ? 1 : 0);
    check_eq("short_pulse_line_len", line_len, HT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side counterpart of the 640x480 VGA timing generator. Samples an incoming hsync/vsync pair once per pixel tick and measures line and frame periods against the expected timing. It declares lock after consecutive good frames, then recovers the pixel coordinates (x, y) and video_on from the sync edges. It sits at the capture end of a VGA link, or on a loopback of our own generator for self-test, and feeds downstream pixel consumers and a status register.

## Interface
- H_TOTAL, 800, pixel ticks per line
- H_DISPLAY, 640, visible pixels per line
- H_SYNC_START, 656, x value of the first tick with hsync asserted
- H_SYNC_WIDTH, 96, hsync pulse width in ticks
- V_TOTAL, 525, lines per frame
- V_DISPLAY, 480, visible lines per frame
- V_SYNC_START, 513, y value of the first line with vsync asserted
- V_SYNC_WIDTH, 2, vsync pulse width in lines
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- p_tick  in  1  pixel-tick enable; inputs are sampled only on clk edges where p_tick=1
- hsync_in  in  1  horizontal sync, asserted high during retrace
- vsync_in  in  1  vertical sync, asserted high during retrace
- locked  out  1  timing matches parameters
- x  out  10  recovered column
- y  out  10  recovered row
- video_on  out  1  locked && x<H_DISPLAY && y<V_DISPLAY
- line_len  out  11  last measured hsync period in ticks
- frame_lines  out  11  last measured vsync period in lines
- err_count  out  8  timing error events, saturating at 255

## Operation
- Edge detection: registered previous hsync/vsync samples update only on p_tick. A rising edge is current=1 and previous=0, evaluated on a p_tick.
- h_meas (11b) resets to 0 on an hsync edge and increments on every other tick. It saturates at 2047.
- h_valid is set by the first hsync edge after reset or SEARCH entry. That first edge only starts measurement.
- On an hsync edge with h_valid=1:
  - line_len <= h_meas+1.
  - Line error if h_meas+1 != H_TOTAL.
  - v_meas increments.
- Timeout: h_meas reaching 2047 is an error. h_valid then clears.
- x: loaded with H_SYNC_START on each hsync edge. Otherwise it increments per tick and wraps from H_TOTAL-1 to 0.
- y: loaded with V_SYNC_START on each vsync edge. Otherwise it increments when x wraps and wraps from V_TOTAL-1 to 0.
- On a vsync edge:
  - frame_lines <= v_meas.
  - Frame error if v_meas != V_TOTAL.
  - v_meas <= 0.
- The frame is good if it has no frame error and no line error since the previous vsync edge.
- When hsync and vsync edges fall on the same tick, the hsync edge is processed first: v_meas increments before the frame check.
- FSM (good_cnt 4b):
  - SEARCH: entered from reset and on any error. The first vsync edge moves to ACQUIRE with good_cnt=0.
  - ACQUIRE: each good frame increments good_cnt. Reaching LOCK_FRAMES moves to LOCKED.
  - LOCKED: locked=1.
  - Any error in ACQUIRE or LOCKED moves to SEARCH and clears good_cnt. The vsync edge that carries the error does not re-enter ACQUIRE.
- err_count: +1 per tick carrying one or more errors. It holds at 255.

## Timing
- All outputs are registered. Reset value of every output and internal state is 0; the FSM resets to SEARCH.
- Latency: a sync edge sampled on tick T is reflected in x, y, line_len, frame_lines, locked and err_count on the clk edge of T. These values are visible the cycle after.
- locked deasserts on the same clk edge as the first error.
- Outputs hold their value on clk edges where p_tick=0.
- Reset asserted mid-frame, including while LOCKED, zeroes everything on the next clk edge regardless of p_tick.

## Configuration
- VGA_MON_PULSE_CHECK_EN defined:
  - Also measures the hsync pulse width in ticks and the vsync pulse width in lines, from rising edge to falling edge.
  - A width != H_SYNC_WIDTH or != V_SYNC_WIDTH, checked at the falling edge, is an error with the same effects as a line error.
- Undefined: pulse widths are ignored and the width counters are not instantiated.

## Test plan
- Ideal generator stream, p_tick every 2nd clk, reset released:
  - locked=0 until the 4th vsync edge: the 1st enters ACQUIRE, the 3rd completes the first fully measured frame, the 4th completes good frame 2. locked=1 then.
  - line_len=800, frame_lines=525, err_count=0.
- Locked stream, one line stretched to 801 ticks:
  - That hsync edge gives line_len=801, locked=0 on the same edge, err_count=1.
  - Relock occurs after the next vsync edge plus 2 good frames.
- Locked stream, hsync held low:
  - 2047 ticks after the last hsync edge the timeout fires: err_count +1, locked=0.
- Locked stream: the vsync edge is forced 1 tick before the hsync edge of the same line and, separately, coincident with it.
  - Same tick: ordering holds and no error.
- Locked stream with reset pulsed for 1 clk mid-frame:
  - Next clk: x=y=0, locked=0, err_count=0, line_len=0.
- With VGA_MON_PULSE_CHECK_EN, locked stream with one hsync pulse of 95 ticks:
  - Error at its falling edge, locked=0, err_count=1.
  - Without the macro, the same stimulus produces no error.
